// File: rtl/scale_pkg.sv
// Shared fixed-point constants, step computation and FSM states for the bilinear scaler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scale_pkg;

   localparam int              FRAC_W  = 16;
   localparam int              COEF_W  = 17;
   localparam logic [16:0]     ONE_Q16 = 17'd65536;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_ROWS = 3'd1,
      RUN_LINE  = 3'd2,
      LINE_END  = 3'd3,
      FRAME_END = 3'd4
   } state_t;

   // Q16 source-per-destination step, floor(src * 65536 / dst); evaluated at elaboration.
   function automatic logic [31:0] calc_step(input int unsigned src, input int unsigned dst);
      logic [47:0] num;
      logic [47:0] den;
      num = {16'd0, src} << FRAC_W;
      den = {16'd0, dst};
      return 32'(num / den);
   endfunction

endpackage

// File: rtl/coef_delay_line.sv
// Delays {valid, fx, fy} so the weights line up with pixels returned by the line buffer.
// Latency: exactly RD_LAT cycles from i_vld to o_vld.
// Backpressure: none; shifts every cycle, valid bits flushed by frame_sync_n.
module coef_delay_line
   import scale_pkg::*;
#(
   parameter int RD_LAT = 1
)(
   input  logic              vin_clk,
   input  logic              rst_n,
   input  logic              frame_sync_n,
   input  logic              i_vld,
   input  logic [FRAC_W-1:0] i_fx,
   input  logic [FRAC_W-1:0] i_fy,
   output logic              o_vld,
   output logic [FRAC_W-1:0] o_fx,
   output logic [FRAC_W-1:0] o_fy
);

   logic [RD_LAT-1:0] r_vld;
   logic [FRAC_W-1:0] r_fx [RD_LAT];
   logic [FRAC_W-1:0] r_fy [RD_LAT];

   // Shift register; a frame restart only kills the valid bits, stale fractions are harmless.
   always_ff @(posedge vin_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            r_fx[i] <= '0;
            r_fy[i] <= '0;
         end
      end else if (!frame_sync_n) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= i_vld;
         r_fx[0]  <= i_fx;
         r_fy[0]  <= i_fy;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_fx[i]  <= r_fx[i-1];
            r_fy[i]  <= r_fy[i-1];
         end
      end
   end

   assign o_vld = r_vld[RD_LAT-1];
   assign o_fx  = r_fx[RD_LAT-1];
   assign o_fy  = r_fy[RD_LAT-1];

endmodule

// File: rtl/bilinear_coord_gen.sv
// Walks destination pixels in raster order, issues 2x2 neighbour reads and emits Q1.16 weights.
// Latency: rd_en one cycle after the FSM visits RUN_LINE; weights/coo_valid RD_LAT cycles after rd_en.
// Backpressure: none downstream; upstream throttled per line on src_rows_done.
module bilinear_coord_gen
   import scale_pkg::*;
#(
   parameter int SRC_W  = 1920,
   parameter int SRC_H  = 1080,
   parameter int DST_W  = 1280,
   parameter int DST_H  = 720,
   parameter int ADDR_W = 11,
   parameter int ROW_W  = 11,
   parameter int RD_LAT = 1
)(
   input  logic              vin_clk,
   input  logic              rst_n,
   input  logic              frame_sync_n,
   input  logic [ROW_W:0]    src_rows_done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_x0,
   output logic [ADDR_W-1:0] rd_x1,
   output logic [ROW_W-1:0]  rd_y0,
   output logic [ROW_W-1:0]  rd_y1,
   output logic              coo_valid,
   output logic [COEF_W-1:0] coefficient1,
   output logic [COEF_W-1:0] coefficient2,
   output logic [COEF_W-1:0] coefficient3,
   output logic [COEF_W-1:0] coefficient4,
   output logic              line_done,
   output logic              frame_done,
   output logic              busy
);

   localparam int XA_W = FRAC_W + ADDR_W + 1;
   localparam int YA_W = FRAC_W + ROW_W + 1;
   localparam int XC_W = $clog2(DST_W + 1);
   localparam int YC_W = $clog2(DST_H + 1);

   localparam logic [XA_W-1:0]   STEP_X     = XA_W'(calc_step(SRC_W, DST_W));
   localparam logic [YA_W-1:0]   STEP_Y     = YA_W'(calc_step(SRC_H, DST_H));
   localparam logic [ADDR_W:0]   X_LAST     = (ADDR_W+1)'(SRC_W - 1);
   localparam logic [ROW_W:0]    Y_LAST     = (ROW_W+1)'(SRC_H - 1);
   localparam logic [ADDR_W-1:0] X_ONE      = ADDR_W'(1);
   localparam logic [ROW_W-1:0]  Y_ONE      = ROW_W'(1);
   localparam logic [ROW_W:0]    ROW_ONE    = (ROW_W+1)'(1);
   localparam logic [XC_W-1:0]   X_CNT_LAST = XC_W'(DST_W - 1);
   localparam logic [YC_W-1:0]   Y_CNT_LAST = YC_W'(DST_H - 1);
   localparam logic [XC_W-1:0]   X_CNT_ONE  = XC_W'(1);
   localparam logic [YC_W-1:0]   Y_CNT_ONE  = YC_W'(1);

   state_t             r_state;
   logic               r_armed;
   logic [XA_W-1:0]    r_x_acc;
   logic [YA_W-1:0]    r_y_acc;
   logic [XC_W-1:0]    r_dst_x;
   logic [YC_W-1:0]    r_dst_y;
   logic               r_rd_en;
   logic [ADDR_W-1:0]  r_rd_x0;
   logic [ADDR_W-1:0]  r_rd_x1;
   logic [ROW_W-1:0]   r_rd_y0;
   logic [ROW_W-1:0]   r_rd_y1;
   logic [FRAC_W-1:0]  r_fx;
   logic [FRAC_W-1:0]  r_fy;
   logic               r_line_done;
   logic               r_frame_done;
   logic               r_busy;

   logic [ADDR_W:0]    w_x_int;
   logic [ROW_W:0]     w_y_int;
   logic [ADDR_W-1:0]  w_x0;
   logic [ADDR_W-1:0]  w_x1;
   logic [ROW_W-1:0]   w_y0;
   logic [ROW_W-1:0]   w_y1;
   logic [FRAC_W-1:0]  w_fx;
   logic [FRAC_W-1:0]  w_fy;
   logic [ROW_W:0]     w_rows_need;
   logic               w_rows_ok;
   logic               w_dvld;
   logic [FRAC_W-1:0]  w_dfx;
   logic [FRAC_W-1:0]  w_dfy;

   // Integer/fraction split of the accumulators; the +1 neighbour is clamped at the right and
   // bottom edges. When the integer part is below the last index, +1 cannot wrap ADDR_W/ROW_W.
   assign w_x_int     = r_x_acc[XA_W-1:FRAC_W];
   assign w_y_int     = r_y_acc[YA_W-1:FRAC_W];
   assign w_x0        = w_x_int[ADDR_W-1:0];
   assign w_y0        = w_y_int[ROW_W-1:0];
   assign w_x1        = (w_x_int >= X_LAST) ? X_LAST[ADDR_W-1:0] : w_x0 + X_ONE;
   assign w_y1        = (w_y_int >= Y_LAST) ? Y_LAST[ROW_W-1:0]  : w_y0 + Y_ONE;
   assign w_fx        = r_x_acc[FRAC_W-1:0];
   assign w_fy        = r_y_acc[FRAC_W-1:0];

   // A line may start once the lower neighbour row has been fully written.
   assign w_rows_need = {1'b0, w_y1} + ROW_ONE;
   assign w_rows_ok   = (src_rows_done >= w_rows_need);

   // Frame sequencer: raster walk, per-line row throttling, registered strobes and addresses.
   always_ff @(posedge vin_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_armed      <= 1'b0;
         r_x_acc      <= '0;
         r_y_acc      <= '0;
         r_dst_x      <= '0;
         r_dst_y      <= '0;
         r_rd_en      <= 1'b0;
         r_rd_x0      <= '0;
         r_rd_x1      <= '0;
         r_rd_y0      <= '0;
         r_rd_y1      <= '0;
         r_fx         <= '0;
         r_fy         <= '0;
         r_line_done  <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else if (!frame_sync_n) begin
         // Restart request wins over everything; the walk resumes from (0,0) on release.
         r_state      <= IDLE;
         r_armed      <= 1'b1;
         r_rd_en      <= 1'b0;
         r_line_done  <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_rd_en      <= 1'b0;
         r_line_done  <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_armed) begin
                  r_armed <= 1'b0;
                  r_x_acc <= '0;
                  r_y_acc <= '0;
                  r_dst_x <= '0;
                  r_dst_y <= '0;
                  r_busy  <= 1'b1;
                  r_state <= WAIT_ROWS;
               end
            end
            WAIT_ROWS: begin
               if (w_rows_ok) begin
                  r_state <= RUN_LINE;
               end
            end
            RUN_LINE: begin
               r_rd_en <= 1'b1;
               r_rd_x0 <= w_x0;
               r_rd_x1 <= w_x1;
               r_rd_y0 <= w_y0;
               r_rd_y1 <= w_y1;
               r_fx    <= w_fx;
               r_fy    <= w_fy;
               r_x_acc <= r_x_acc + STEP_X;
               if (r_dst_x == X_CNT_LAST) begin
                  r_dst_x <= '0;
                  r_state <= LINE_END;
               end else begin
                  r_dst_x <= r_dst_x + X_CNT_ONE;
               end
            end
            LINE_END: begin
               r_line_done <= 1'b1;
               r_x_acc     <= '0;
               r_y_acc     <= r_y_acc + STEP_Y;
               if (r_dst_y == Y_CNT_LAST) begin
                  r_dst_y <= '0;
                  r_state <= FRAME_END;
               end else begin
                  r_dst_y <= r_dst_y + Y_CNT_ONE;
                  r_state <= WAIT_ROWS;
               end
            end
            FRAME_END: begin
               r_frame_done <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   coef_delay_line #(
      .RD_LAT       (RD_LAT)
   ) u_coef_delay_line (
      .vin_clk      (vin_clk),
      .rst_n        (rst_n),
      .frame_sync_n (frame_sync_n),
      .i_vld        (r_rd_en),
      .i_fx         (r_fx),
      .i_fy         (r_fy),
      .o_vld        (w_dvld),
      .o_fx         (w_dfx),
      .o_fy         (w_dfy)
   );

   assign rd_en        = r_rd_en;
   assign rd_x0        = r_rd_x0;
   assign rd_x1        = r_rd_x1;
   assign rd_y0        = r_rd_y0;
   assign rd_y1        = r_rd_y1;
   assign line_done    = r_line_done;
   assign frame_done   = r_frame_done;
   assign busy         = r_busy;

   // Weights are forced to zero outside valid cycles; a zero fraction yields the full 65536.
   assign coo_valid    = w_dvld;
   assign coefficient1 = w_dvld ? (ONE_Q16 - {1'b0, w_dfx}) : '0;
   assign coefficient2 = w_dvld ? {1'b0, w_dfx}             : '0;
   assign coefficient3 = w_dvld ? (ONE_Q16 - {1'b0, w_dfy}) : '0;
   assign coefficient4 = w_dvld ? {1'b0, w_dfy}             : '0;

endmodule
